// File: rtl/vscale_imem_prefetch.sv
// vscale_imem_prefetch
//
// Instruction prefetch queue in front of the read-only port (p1) of the
// dual-port HASTI SRAM. Sequential word reads are issued while the queue
// has credit; returned words are queued and handed to the core fetch stage
// over a valid/ready handshake. A redirect flushes the queue, restarts fetch
// at the new address and squashes any read still in its data phase.
//
// Ports
//   hclk, hresetn      clock, synchronous active-low reset
//   redirect           flush queue and restart fetch at redirect_pc
//   redirect_pc        new fetch address (bits [1:0] forced to zero)
//   inst_valid         head entry valid
//   inst_ready         core accepts head entry
//   inst_data          head instruction word
//   inst_pc            address of head word
//   inst_err           head word came back with an ERROR response
//   mem_addr/mem_read  address phase to SRAM p1
//   mem_rdata          read data from SRAM p1
//   mem_ready          SRAM p1 ready (low extends the data phase)
//   mem_resp           SRAM p1 response (0 = OKAY, 1 = ERROR)

module vscale_imem_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h200
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_err,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_resp
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;

   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic          q_err  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [31:0]   fetch_pc;
   logic [31:0]   dp_pc;      // address of the read currently in its data phase
   logic          inflight;
   logic          squash;

   logic          push;
   logic          pop;
   logic          credit_ok;
   logic [SW-1:0] credit_sum;
   logic [31:0]   target_pc;

   // Low address bits of the redirect target are forced to zero.
   logic          unused_pc_bits;
   assign unused_pc_bits = ^redirect_pc[1:0];

   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
   assign inst_err   = inst_valid ? q_err[rd_ptr]  : 1'b0;

   always_comb begin
      target_pc  = {redirect_pc[31:2], 2'b00};
      push       = inflight & mem_ready & ~squash & ~redirect;
      pop        = inst_valid & inst_ready & ~redirect;
      // Occupancy after this edge (pops excluded, so a pop only frees credit
      // next cycle) plus the read whose address phase completes now.
      credit_sum = {1'b0, count} + SW'(push) + SW'(mem_read);
      credit_ok  = credit_sum < SW'(DEPTH);
   end

   // Queue storage carries data only; validity lives in count.
   always_ff @(posedge hclk) begin
      if (push) begin
         q_data[wr_ptr] <= mem_rdata;
         q_pc[wr_ptr]   <= dp_pc;
         q_err[wr_ptr]  <= mem_resp;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
         mem_read <= 1'b0;
         dp_pc    <= '0;
         inflight <= 1'b0;
         squash   <= 1'b0;
      end else if (redirect) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fetch_pc <= target_pc;
         mem_addr <= target_pc;
         mem_read <= 1'b0;
         if (mem_ready) begin
            // A read accepted on this edge belongs to the old stream.
            inflight <= mem_read;
            squash   <= mem_read;
            dp_pc    <= mem_addr;
         end else begin
            // Data phase still pending; its word must be dropped on return.
            squash   <= squash | inflight;
         end
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (mem_ready) begin
            inflight <= mem_read;
            squash   <= 1'b0;
            dp_pc    <= mem_addr;
            mem_read <= credit_ok;
            mem_addr <= fetch_pc;
            if (credit_ok) fetch_pc <= fetch_pc + 32'd4;
         end
      end
   end

endmodule

// File: doc/vscale_imem_prefetch.md
Name: vscale_imem_prefetch

Overview:
- Instruction prefetch queue sitting directly upstream of the dual-port HASTI SRAM's read-only port (p1).
- Issues sequential word reads whenever the queue has credit and captures returned words. SRAM data returns one cycle after the address phase because the SRAM registers the address.
- Presents instructions to the core fetch stage over a valid/ready handshake. Supports redirect (branch/trap) with flush and squash of the in-flight read.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h200, first fetch address after reset.

Ports:
- hclk  in  1  clock
- hresetn  in  1  synchronous active-low reset
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- inst_valid  out  1  head entry valid
- inst_ready  in  1  core accepts head entry
- inst_data  out  32  head instruction word
- inst_pc  out  32  address of head word
- inst_err  out  1  head word returned with HASTI ERROR response
- mem_addr  out  32  address to SRAM p1_addr
- mem_read  out  1  read request to SRAM p1_read
- mem_rdata  in  32  from SRAM p1_rdata
- mem_ready  in  1  from SRAM p1_ready
- mem_resp  in  1  from SRAM p1_resp (0 = OKAY, 1 = ERROR)

Behaviour:
- Reset (hresetn low at posedge):
  - Queue empty; inst_valid=0; inst_data=0; inst_pc=0; inst_err=0.
  - fetch_pc=RESET_PC; mem_addr=RESET_PC; mem_read=0; inflight=0; squash=0.
- Issue:
  - mem_read is registered. It is asserted in cycle N when (occupancy + inflight) < DEPTH, no redirect is in that cycle, and mem_ready=1.
  - mem_addr = fetch_pc. fetch_pc advances by 4 on issue, wrapping mod 2^32 (32'hFFFFFFFC -> 0).
  - First issue occurs in the first cycle after hresetn is released.
- Data phase:
  - Word for an issue in cycle N is sampled at the end of cycle N+1 if mem_ready=1.
  - If mem_ready=0, the data phase extends. mem_addr and mem_read hold, no new issue is made, and the sample retries next cycle.
  - At most one read in flight; back-to-back pipelined issue is allowed (issue N+1 overlaps data phase of N).
- Push: the sampled word is written at the tail with pc = issued address and err = mem_resp. It is discarded if the squash flag is set for that read.
- Pop:
  - inst_valid = occupancy != 0. Head fields are driven combinationally from queue storage.
  - inst_valid && inst_ready removes the head.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Credit: occupancy + inflight never exceeds DEPTH. A pop does not grant same-cycle issue credit; credit appears next cycle.
- Full: occupancy=DEPTH -> mem_read=0; inst_valid stays 1 until popped.
- Empty: inst_valid=0; inst_ready is ignored.
- Redirect (sampled at posedge):
  - Queue is cleared, so inst_valid=0 the next cycle.
  - Any pop in the redirect cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Outstanding read, if any, is marked squash and its data is dropped.
  - mem_read=0 in the cycle after the redirect. Issue of the redirect target starts the following cycle, so the first target word is visible on inst_valid 3 cycles after redirect.
- Back-to-back redirects: the last one wins; earlier targets are never pushed.
- Error response: the word is pushed with inst_err=1 and fetch continues sequentially. The core decides on the trap and redirects.
- Pointers wrap modulo DEPTH. No overflow or underflow is possible; the bench asserts this.
- Reset mid-operation: all state returns to reset values in one cycle, and in-flight data is not pushed.

Test Plan:
- Reset release, inst_ready=1, SRAM words[0x80..]=0x13,0x93,... -> inst_pc 0x200,0x204,0x208 on consecutive cycles starting 2 cycles after reset. Throughput 1 word/cycle; data matches memory.
- inst_ready=0 for 10 cycles -> mem_read stops once occupancy+inflight=4. Exactly 4 entries (0x200-0x20C) are held; after release they drain in order with no gap and no duplicate.
- redirect to 0x1003 while a read of 0x208 is in flight -> 0x208 is never presented. Next inst_pc is 0x1000, 3 cycles after redirect.
- redirect asserted with inst_valid && inst_ready in the same cycle -> head is not counted as consumed and the queue is empty next cycle.
- mem_resp=1 on the read of 0x204 -> entry 0x204 has inst_err=1; 0x208 follows with inst_err=0.
- Redirect to 0xFFFFFFF8 -> fetch order 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; mem_ready held low for 2 cycles mid-stream stalls without loss or duplication.
